// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing a 3-to-8 decoded select.
// Grant index and one-hot grant are registered; a grant is held until done, request drop, or MAX_HOLD.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no grant; arbitrate from ptr when any request is pending
//   GRANT   | gnt_idx owns the resource; hold_cnt counts owned cycles
//   RELEASE | one-cycle bus turnaround gap before arbitration resumes
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt_onehot,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0] pick;
  logic [2:0] cand;
  logic       found;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_max;

  // First set request in the order ptr, ptr+1, ..., ptr+7 with 3-bit wrap.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign rel_done = done;
  assign rel_drop = ~req[gnt_idx];
  assign rel_max  = (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= 3'd0;
      gnt_onehot <= 8'h00;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (found) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= pick;
            gnt_onehot <= 8'(1) << pick;
            hold_cnt   <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_max) begin
            state      <= RELEASE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= 8'h00;
            ptr        <= gnt_idx + 3'd1;
            // A normal completion on the limit cycle is not a timeout.
            timeout    <= rel_max && !rel_done && !rel_drop;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          state   <= IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= 8'h00;
          timeout    <= 1'b0;
        end
      endcase
    end
  end

endmodule
